// File: rtl/div64x32_if.sv
// div64x32_if: start/busy handshake and operand/result bus of the
// sequential 64/32 divider.
//   start       - request, sampled by the divider only while busy=0
//   dividend    - 2*N_BITS unsigned dividend, sampled with start
//   divisor     - N_BITS unsigned divisor, sampled with start
//   busy        - operation in progress
//   quotient    - registered quotient of the last completed operation
//   remainder   - registered remainder of the last completed operation
//   div_by_zero - last operation had divisor == 0
//   overflow    - last operation's quotient did not fit in N_BITS
// The master modport is the requester side; the slave modport is the divider.
interface div64x32_if #(
  parameter int N_BITS = 32
);
  logic                  start;
  logic [2*N_BITS-1:0]   dividend;
  logic [N_BITS-1:0]     divisor;
  logic                  busy;
  logic [N_BITS-1:0]     quotient;
  logic [N_BITS-1:0]     remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div64x32.sv
// div64x32: sequential unsigned divider, 2*N_BITS-bit dividend by N_BITS-bit
// divisor, radix-2 restoring, one quotient bit per clock.
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-low reset
//   bus   - div64x32_if slave: start/dividend/divisor in,
//           busy/quotient/remainder/div_by_zero/overflow out
// A valid operation keeps busy high for N_BITS cycles; divide-by-zero and
// quotient overflow are detected at the start edge and complete after one
// cycle with quotient = all ones.
module div64x32 #(
  parameter int N_BITS = 32
) (
  input  logic           clk,
  input  logic           reset,
  div64x32_if.slave      bus
);

  localparam int CW = $clog2(N_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
  logic [N_BITS-1:0]   shq_q, shq_d;     // dividend low bits out, quotient bits in
  logic [N_BITS-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [N_BITS-1:0]   quot_q, quot_d;
  logic [N_BITS-1:0]   remo_q, remo_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;

  // Restoring step: trial is one bit wider than the remainder because the
  // shifted remainder can reach 2*divisor-1.
  logic [N_BITS:0]     trial;
  logic                fits;
  logic [N_BITS-1:0]   diff;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shq_d   = shq_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    trial = {rem_q, shq_q[N_BITS-1]};
    fits  = (trial >= {1'b0, dvsr_q});
    // Difference is below divisor whenever it is used, so N_BITS suffice.
    diff  = trial[N_BITS-1:0] - dvsr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvsr_d = bus.divisor;
          shq_d  = bus.dividend[N_BITS-1:0];
          rem_d  = bus.dividend[2*N_BITS-1:N_BITS];
          cnt_d  = '0;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          if ((bus.divisor == '0) ||
              (bus.dividend[2*N_BITS-1:N_BITS] >= bus.divisor)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = fits ? diff : trial[N_BITS-1:0];
        // Dividend bits leave at the top while quotient bits enter at the
        // bottom, so after N_BITS steps this register holds the quotient.
        shq_d = {shq_q[N_BITS-2:0], fits};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N_BITS - 1)) begin
          quot_d  = {shq_q[N_BITS-2:0], fits};
          remo_d  = fits ? diff : trial[N_BITS-1:0];
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        // Divide-by-zero wins over overflow: a zero divisor always lands here
        // flagged as div_by_zero, anything else reaching FAULT is overflow.
        quot_d  = '1;
        dbz_d   = (dvsr_q == '0);
        ovf_d   = (dvsr_q != '0);
        remo_d  = (dvsr_q == '0) ? shq_q : '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shq_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shq_q   <= shq_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/div64x32.md
Name: div64x32

Overview:
- Sequential unsigned divider: 64-bit dividend ÷ 32-bit divisor → 32-bit quotient and 32-bit remainder.
- Inverse datapath of the 32x32 multiplier: its 64-bit product width feeds the dividend directly, so product/divisor round-trips exactly.
- Uses the same start/busy handshake as the multiplier.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- N_BITS, 32, divisor/quotient/remainder width; dividend is 2*N_BITS. Only 32 is verified.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only when busy=0
- dividend  input  64  unsigned dividend, sampled with start
- divisor  input  32  unsigned divisor, sampled with start
- busy  output  1  operation in progress
- quotient  output  32  registered result
- remainder  output  32  registered result
- div_by_zero  output  1  last op had divisor==0
- overflow  output  1  last op had a quotient that does not fit in 32 bits (dividend[63:32] >= divisor, divisor!=0)

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE; busy, quotient, remainder, div_by_zero, overflow all 0; internal registers cleared.
  - An operation in flight is abandoned; no result is produced.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, iterating.
  - FAULT: busy=1, exactly one cycle.
- IDLE, edge E0 with start=1:
  - Latch dividend and divisor; clear div_by_zero and overflow; busy=1 from E0.
  - divisor==0 → FAULT; div_by_zero=1 at E1.
  - dividend[63:32] >= divisor → FAULT; overflow=1 at E1.
  - Otherwise → RUN: partial remainder R (33 bits) = {0, dividend[63:32]}; shift register holds dividend[31:0]; step counter=0.
- IDLE with start=0: hold all outputs.
- RUN, each edge:
  - T = {R[31:0], next dividend bit, MSB first}.
  - If T >= {0, divisor}: R = T - divisor, quotient bit = 1; else R = T, quotient bit = 0.
  - Quotient bits shift into a working register; counter increments.
- RUN, 32nd edge (E32):
  - quotient ← working quotient; remainder ← R[31:0]; busy=0; state → IDLE.
  - Latency: start edge to result edge = 32 cycles; busy high for exactly 32 cycles.
- FAULT, edge E1:
  - quotient=32'hFFFF_FFFF.
  - remainder = dividend[31:0] on div_by_zero; 0 on overflow.
  - busy=0; state → IDLE. Latency 1 cycle.
  - div_by_zero takes priority when both conditions hold.
- Output holding:
  - quotient, remainder and flags change only at a completion edge or at reset.
  - Between completions they hold the last result.
  - Flags clear at the next accepted start.
- start while busy=1: ignored; operands not resampled.
- start held high:
  - A new operation is accepted on the first edge where busy=0, i.e. the edge after completion, since busy is registered.
  - Back-to-back operations therefore leave one IDLE cycle between them.
- Input changes while busy: no effect on the result.
- Arithmetic: unsigned only; no rounding. When overflow=0 and div_by_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset 4 cycles, release, start with dividend=44465621733294059, divisor=212015051 → busy high 32 cycles; quotient=209728609, remainder=0, flags 0.
- dividend=100, divisor=7 → after 32 cycles: quotient=14, remainder=2; dividend=44465621733294066, divisor=212015051 → quotient=209728609, remainder=7.
- divisor=0, dividend=64'h0000_0001_2345_6789 → busy high 1 cycle; div_by_zero=1, overflow=0, quotient=FFFF_FFFF, remainder=2345_6789.
- dividend=64'h0000_0005_0000_0000, divisor=5 → overflow=1, quotient=FFFF_FFFF, remainder=0, busy 1 cycle. Then 100/7 → overflow clears at start and the correct result is produced.
- Start 100/7, pulse start with new operands at cycle 10, then drive reset=0 asynchronously (mid-cycle) at cycle 20 → outputs 0 immediately, busy=0. After release, a fresh 100/7 completes in 32 cycles with quotient=14, remainder=2.
- Hold start=1 continuously with dividend=1000, divisor=10 → quotient=100, remainder=0 each run. Busy shows a 32-high/1-low period, and outputs are stable across the low cycle.
